// File: rtl/cordic_vector_if.sv
// Handshake bundle for cordic_vector: sample input channel and mag/angle result channel.
interface cordic_vector_if;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] xin;
   logic signed [15:0] yin;
   logic               out_valid;
   logic               out_ready;
   logic [16:0]        mag;
   logic [31:0]        angle;

   modport master (
      output in_valid, xin, yin, out_ready,
      input  in_ready, out_valid, mag, angle
   );

   modport slave (
      input  in_valid, xin, yin, out_ready,
      output in_ready, out_valid, mag, angle
   );
endinterface

// File: rtl/cordic_vector.sv
// Iterative vectoring CORDIC: (I,Q) -> (magnitude, 32-bit phase word), one micro-rotation per clock.
// Define CORDIC_VEC_GAIN_COMP_EN to add the GAIN state that scales mag back to ~|v|.
//
// state  | meaning
// S_IDLE | waiting for a sample; in_ready high
// S_ITER | micro-rotation r_cnt in progress
// S_GAIN | CORDIC gain compensation of x (only with CORDIC_VEC_GAIN_COMP_EN)
// S_DONE | result valid, held until out_ready
module cordic_vector #(
   parameter int ITER = 16
) (
   input  logic           clock,
   input  logic           reset,
   cordic_vector_if.slave bus
);

`ifdef CORDIC_VEC_GAIN_COMP_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_GAIN = 2'd2, S_DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd3} state_t;
`endif

   localparam logic [3:0] LAST = 4'(ITER - 1);

   state_t             r_state, w_next;
   logic signed [18:0] r_x, r_y;
   logic [31:0]        r_z;
   logic [3:0]         r_cnt;
   logic               r_zero;
   logic [16:0]        r_mag;
   logic [31:0]        r_angle;

   logic               w_in_ready, w_out_valid, w_last;
   logic signed [18:0] w_xin, w_yin, w_fx, w_fy;
   logic [31:0]        w_fz;
   logic signed [18:0] w_xs, w_ys, w_x_next, w_y_next;
   logic [31:0]        w_atan, w_z_next;

   function automatic logic [31:0] atan_lut(input logic [3:0] i);
      case (i)
         4'd0:  atan_lut = 32'h2000_0000;
         4'd1:  atan_lut = 32'h12E4_051D;
         4'd2:  atan_lut = 32'h09FB_385B;
         4'd3:  atan_lut = 32'h0511_11D4;
         4'd4:  atan_lut = 32'h028B_0D43;
         4'd5:  atan_lut = 32'h0145_D7E1;
         4'd6:  atan_lut = 32'h00A2_F61E;
         4'd7:  atan_lut = 32'h0051_7C55;
         4'd8:  atan_lut = 32'h0028_BE53;
         4'd9:  atan_lut = 32'h0014_5F2E;
         4'd10: atan_lut = 32'h000A_2F98;
         4'd11: atan_lut = 32'h0005_17CC;
         4'd12: atan_lut = 32'h0002_8BE6;
         4'd13: atan_lut = 32'h0001_45F3;
         4'd14: atan_lut = 32'h0000_A2F9;
         4'd15: atan_lut = 32'h0000_517C;
      endcase
   endfunction

   assign w_xin  = {{3{bus.xin[15]}}, bus.xin};
   assign w_yin  = {{3{bus.yin[15]}}, bus.yin};
   assign w_last = (r_cnt == LAST);

   // Fold the left half-plane into the right so the iterations converge.
   always_comb begin
      w_fx = w_xin;
      w_fy = w_yin;
      w_fz = 32'h0000_0000;
      if (bus.xin < 0) begin
         if (bus.yin >= 0) begin
            w_fx = w_yin;
            w_fy = -w_xin;
            w_fz = 32'h4000_0000;
         end else begin
            w_fx = -w_yin;
            w_fy = w_xin;
            w_fz = 32'hC000_0000;
         end
      end
   end

   assign w_xs   = r_x >>> r_cnt;
   assign w_ys   = r_y >>> r_cnt;
   assign w_atan = atan_lut(r_cnt);

   always_comb begin
      w_x_next = r_x;
      w_y_next = r_y;
      w_z_next = r_z;
      if (r_y >= 0) begin
         w_x_next = r_x + w_ys;
         w_y_next = r_y - w_xs;
         w_z_next = r_z + w_atan;
      end else begin
         w_x_next = r_x - w_ys;
         w_y_next = r_y + w_xs;
         w_z_next = r_z - w_atan;
      end
   end

`ifdef CORDIC_VEC_GAIN_COMP_EN
   logic signed [18:0] w_gain;
   assign w_gain = (r_x >>> 1) + (r_x >>> 4) + (r_x >>> 5) + (r_x >>> 6) - (r_x >>> 9);
`endif

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_next = S_ITER;
         end
         S_ITER: begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
            if (w_last) w_next = S_GAIN;
`else
            if (w_last) w_next = S_DONE;
`endif
         end
`ifdef CORDIC_VEC_GAIN_COMP_EN
         S_GAIN: w_next = S_DONE;
`endif
         S_DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_cnt   <= '0;
         r_zero  <= 1'b0;
         r_mag   <= '0;
         r_angle <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_x    <= w_fx;
                  r_y    <= w_fy;
                  r_z    <= w_fz;
                  r_cnt  <= '0;
                  r_zero <= (bus.xin == 16'sd0) && (bus.yin == 16'sd0);
               end
            end
            S_ITER: begin
               r_x   <= w_x_next;
               r_y   <= w_y_next;
               r_z   <= w_z_next;
               r_cnt <= r_cnt + 4'd1;
`ifndef CORDIC_VEC_GAIN_COMP_EN
               if (w_last) begin
                  r_mag   <= r_zero ? '0 : 17'(w_x_next);
                  r_angle <= r_zero ? '0 : w_z_next;
               end
`endif
            end
`ifdef CORDIC_VEC_GAIN_COMP_EN
            S_GAIN: begin
               r_mag   <= r_zero ? '0 : 17'(w_gain);
               r_angle <= r_zero ? '0 : r_z;
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.mag       = r_mag;
   assign bus.angle     = r_angle;

endmodule

// File: tb/tb_cordic_vector.sv
// Self-checking bench for cordic_vector: vector table with real-math model, scoreboard, corner sequences.
module tb_cordic_vector;
   localparam int  ITER = 16;
   localparam real PI   = 3.14159265358979;
   localparam real KC   = 1.6467602581;
`ifdef CORDIC_VEC_GAIN_COMP_EN
   localparam int  LAT  = ITER + 1;
   localparam real GK   = KC * 0.607421875;
`else
   localparam int  LAT  = ITER;
   localparam real GK   = KC;
`endif

   typedef struct {
      logic [31:0] ang;
      int          mag;
      int          tol;
   } exp_t;

   typedef struct {
      logic signed [15:0] x;
      logic signed [15:0] y;
      exp_t               e;
   } vec_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   cordic_vector_if bus();
   cordic_vector #(.ITER(ITER)) dut (.clock(clock), .reset(reset), .bus(bus));

   localparam int NV = 12;
   vec_t vecs[NV];
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic exp_t model(input int x, input int y);
      exp_t e;
      real  a, m;
      if (x == 0 && y == 0) begin
         e.ang = 32'h0;
         e.mag = 0;
         e.tol = 0;
      end else begin
         a     = $atan2(real'(y), real'(x)) / (2.0 * PI);
         e.ang = 32'(longint'(a * 4294967296.0));
         m     = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * GK;
         e.mag = int'(m);
         e.tol = 8;
      end
      return e;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp, input longint tol);
      longint d;
      n_tests++;
      d = act - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, exp, tol);
      end
   endtask

   task automatic chk_ang(input string nm, input logic [31:0] act, input logic [31:0] exp, input int tol);
      logic [31:0] d;
      longint      sd;
      n_tests++;
      d  = act - exp;
      sd = longint'($signed(d));
      if (sd < 0) sd = -sd;
      if (sd > longint'(tol)) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (tol 0x%0h)", nm, act, exp, tol);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accept edge.
   task automatic accept(input string nm, input logic signed [15:0] x, input logic signed [15:0] y);
      int t;
      t = 0;
      while (!bus.in_ready && t < 100) begin
         @(negedge clock);
         t++;
      end
      chk({nm, " in_ready before accept"}, bus.in_ready, 1, 0);
      bus.xin      = x;
      bus.yin      = y;
      bus.in_valid = 1'b1;
      sb.push_back(model(x, y));
      @(posedge clock);
      #1 bus.in_valid = 1'b0;
      @(negedge clock);
   endtask

   task automatic wait_valid(input string nm, output bit ok);
      int lat;
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         @(negedge clock);
         lat++;
      end
      ok = bus.out_valid;
      chk({nm, " latency"}, lat, LAT, 0);
   endtask

   task automatic take_out(input string nm);
      exp_t e;
      e = sb.pop_front();
      chk({nm, " mag"}, bus.mag, e.mag, e.tol);
      chk_ang({nm, " angle"}, bus.angle, e.ang, (e.tol == 0) ? 0 : 32'h0010_0000);
      bus.out_ready = 1'b1;
      @(posedge clock);
      #1 bus.out_ready = 1'b0;
      @(negedge clock);
      chk({nm, " out_valid after take"}, bus.out_valid, 0, 0);
      chk({nm, " in_ready after take"}, bus.in_ready, 1, 0);
   endtask

   task automatic run_one(input string nm, input logic signed [15:0] x, input logic signed [15:0] y);
      bit ok;
      accept(nm, x, y);
      wait_valid(nm, ok);
      if (ok) take_out(nm);
      else    void'(sb.pop_front());
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  xs[NV] = '{16384, 0, -16384, -16384, -32768, 0, 16384, 0, -16384, 10000, 12000, -7000};
      int  ys[NV] = '{0, 16384, 0, -16384, -32768, 0, 16384, -16384, 16384, -10000, -5000, 3000};
      bit  ok;
      int  seen;
      exp_t e;

      for (int i = 0; i < NV; i++) begin
         vecs[i].x = 16'(xs[i]);
         vecs[i].y = 16'(ys[i]);
         vecs[i].e = model(xs[i], ys[i]);
      end

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.xin       = '0;
      bus.yin       = '0;
      repeat (3) @(negedge clock);
      chk("reset in_ready", bus.in_ready, 1, 0);
      chk("reset out_valid", bus.out_valid, 0, 0);
      chk("reset mag", bus.mag, 0, 0);
      chk("reset angle", bus.angle, 0, 0);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < NV; i++) begin
         run_one($sformatf("vec%0d(%0d,%0d)", i, vecs[i].x, vecs[i].y), vecs[i].x, vecs[i].y);
      end

      // Backpressure: result held, in_ready low, stray in_valid pulse ignored.
      accept("bp", 16'sd16384, 16'sd16384);
      wait_valid("bp", ok);
      e = model(16384, 16384);
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            bus.xin      = 16'sd100;
            bus.yin      = 16'sd100;
            bus.in_valid = 1'b1;
         end
         @(posedge clock);
         #1 bus.in_valid = 1'b0;
         @(negedge clock);
         chk($sformatf("bp hold%0d out_valid", c), bus.out_valid, 1, 0);
         chk($sformatf("bp hold%0d in_ready", c), bus.in_ready, 0, 0);
         chk($sformatf("bp hold%0d mag", c), bus.mag, e.mag, e.tol);
         chk_ang($sformatf("bp hold%0d angle", c), bus.angle, e.ang, 32'h0010_0000);
      end
      if (ok) take_out("bp");
      else    void'(sb.pop_front());
      accept("bp next", 16'sd10000, -16'sd10000);
      chk("bp next accepted at F+1", bus.in_ready, 0, 0);
      wait_valid("bp next", ok);
      if (ok) take_out("bp next");
      else    void'(sb.pop_front());

      // Reset during iteration 7 aborts without producing a result.
      accept("rst", 16'sd16384, 16'sd0);
      repeat (7) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("midrst in_ready", bus.in_ready, 1, 0);
      chk("midrst out_valid", bus.out_valid, 0, 0);
      chk("midrst mag", bus.mag, 0, 0);
      chk("midrst angle", bus.angle, 0, 0);
      sb.delete();
      seen = 0;
      repeat (LAT + 4) begin
         @(negedge clock);
         if (bus.out_valid) seen++;
      end
      chk("midrst aborted no output", seen, 0, 0);
      run_one("after rst", 16'sd16384, 16'sd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
